product_accumulator: RTL and testbench

- Downstream consumer of the 4x4 combinational multiplier's 8-bit product.
- Accumulates a stream of products into a dot-product style sum over one vector:
  - a vector ends on an explicit last flag, or when MAX_LEN beats have been accepted;
  - the sum is then presented on a valid/ready result port.
- Sits between the multiplier array and the result consumer (display/UART/register file).

---
 rtl/product_accumulator.sv | 87 ++++++++
 tb/tb_product_accumulator.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Accumulates a stream of unsigned multiplier products into one sum per vector and
// presents the sum, beat count and wrap flag on a valid/ready result port.
module product_accumulator #(
    parameter int PROD_W  = 8,
    parameter int ACC_W   = 16,
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_overflow
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             ovf;

    logic [ACC_W:0]   sum_ext;
    logic [CNT_W-1:0] count_next;
    logic             accept;
    logic             terminate;

    // The extra MSB of sum_ext is the carry-out of the unsigned addition.
    assign sum_ext    = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_product};
    assign count_next = count + 1'b1;
    assign accept     = in_valid && (state == ACCUM);
    assign terminate  = in_last || (count_next == CNT_W'(MAX_LEN));

    // Handshake flags decode straight from the state register, so they are glitch-free.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);

    // NOTE: all state updates use non-blocking assignments so every register sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ACCUM;
            acc          <= '0;
            count        <= '0;
            ovf          <= 1'b0;
            out_sum      <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc   <= sum_ext[ACC_W-1:0];
                        count <= count_next;
                        ovf   <= ovf | sum_ext[ACC_W];
                        if (terminate) begin
                            state        <= HOLD;
                            out_sum      <= sum_ext[ACC_W-1:0];
                            out_count    <= count_next;
                            out_overflow <= ovf | sum_ext[ACC_W];
                        end
                    end
                end
                HOLD: begin
                    // Result registers keep their values after the handshake.
                    if (out_ready) begin
                        state <= ACCUM;
                        acc   <= '0;
                        count <= '0;
                        ovf   <= 1'b0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a cycle table for the basic and backpressure
// flows, then hand-written sequences for forced termination, overflow and resets.
module tb_product_accumulator;

    localparam int PROD_W = 8;
    localparam int CNT_W  = 5;

    logic clk;
    logic rst;

    // Default-width instance
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_product;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_overflow;

    // Narrow-accumulator instance for wrap checks
    logic              n_in_valid;
    logic              n_in_ready;
    logic [PROD_W-1:0] n_in_product;
    logic              n_in_last;
    logic              n_out_valid;
    logic              n_out_ready;
    logic [9:0]        n_out_sum;
    logic [CNT_W-1:0]  n_out_count;
    logic              n_out_overflow;

    int pass_count;
    int check_count;

    product_accumulator dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_product   (in_product),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_count    (out_count),
        .out_overflow (out_overflow)
    );

    product_accumulator #(.ACC_W(10)) dut_narrow (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (n_in_valid),
        .in_ready     (n_in_ready),
        .in_product   (n_in_product),
        .in_last      (n_in_last),
        .out_valid    (n_out_valid),
        .out_ready    (n_out_ready),
        .out_sum      (n_out_sum),
        .out_count    (n_out_count),
        .out_overflow (n_out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [7:0] product;
        logic       last;
        logic       ready_out;
        logic       exp_in_ready;
        logic       exp_out_valid;
        int         exp_sum;
        int         exp_count;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input int actual, input int expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Apply inputs for one cycle and advance to the next falling edge.
    task automatic drive(input logic v, input logic [7:0] p, input logic l, input logic r);
        in_valid   = v;
        in_product = p;
        in_last    = l;
        out_ready  = r;
        @(negedge clk);
    endtask

    task automatic drive_n(input logic v, input logic [7:0] p, input logic l, input logic r);
        n_in_valid   = v;
        n_in_product = p;
        n_in_last    = l;
        n_out_ready  = r;
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input int v, input int s, input int c, input int o);
        check({tag, "_valid"}, int'(out_valid), v);
        check({tag, "_sum"}, int'(out_sum), s);
        check({tag, "_count"}, int'(out_count), c);
        check({tag, "_ovf"}, int'(out_overflow), o);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pass_count  = 0;
        check_count = 0;

        //            v  prod last ordy  rdy val sum  cnt ovf
        vecs[0]  = '{1'b1, 8'd15,  1'b0, 1'b1, 1'b1, 1'b0, 0,   0, 1'b0};
        vecs[1]  = '{1'b1, 8'd225, 1'b0, 1'b1, 1'b1, 1'b0, 0,   0, 1'b0};
        vecs[2]  = '{1'b1, 8'd6,   1'b1, 1'b1, 1'b1, 1'b0, 0,   0, 1'b0};
        vecs[3]  = '{1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 1'b1, 246, 3, 1'b0};
        vecs[4]  = '{1'b0, 8'd0,   1'b0, 1'b0, 1'b1, 1'b0, 246, 3, 1'b0};
        vecs[5]  = '{1'b1, 8'd10,  1'b0, 1'b0, 1'b1, 1'b0, 246, 3, 1'b0};
        vecs[6]  = '{1'b1, 8'd20,  1'b1, 1'b0, 1'b1, 1'b0, 246, 3, 1'b0};
        vecs[7]  = '{1'b1, 8'd99,  1'b0, 1'b0, 1'b0, 1'b1, 30,  2, 1'b0};
        vecs[8]  = '{1'b1, 8'd99,  1'b0, 1'b0, 1'b0, 1'b1, 30,  2, 1'b0};
        vecs[9]  = '{1'b1, 8'd99,  1'b0, 1'b0, 1'b0, 1'b1, 30,  2, 1'b0};
        vecs[10] = '{1'b1, 8'd99,  1'b0, 1'b0, 1'b0, 1'b1, 30,  2, 1'b0};
        vecs[11] = '{1'b1, 8'd99,  1'b0, 1'b0, 1'b0, 1'b1, 30,  2, 1'b0};
        vecs[12] = '{1'b1, 8'd99,  1'b0, 1'b1, 1'b0, 1'b1, 30,  2, 1'b0};
        vecs[13] = '{1'b1, 8'd99,  1'b1, 1'b1, 1'b1, 1'b0, 30,  2, 1'b0};
        vecs[14] = '{1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 1'b1, 99,  1, 1'b0};
        vecs[15] = '{1'b0, 8'd0,   1'b0, 1'b0, 1'b1, 1'b0, 99,  1, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0; in_product = '0; in_last = 1'b0; out_ready = 1'b0;
        n_in_valid = 1'b0; n_in_product = '0; n_in_last = 1'b0; n_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Table: basic vector (rows 0-4) then backpressure with a held beat (rows 5-15)
        foreach (vecs[i]) begin
            check($sformatf("row%0d_in_ready", i), int'(in_ready), int'(vecs[i].exp_in_ready));
            check_out($sformatf("row%0d", i), int'(vecs[i].exp_out_valid), vecs[i].exp_sum,
                      vecs[i].exp_count, int'(vecs[i].exp_ovf));
            drive(vecs[i].valid, vecs[i].product, vecs[i].last, vecs[i].ready_out);
        end

        // Forced termination after 16 beats without in_last
        for (int i = 0; i < 16; i++) begin
            check($sformatf("ft_ready%0d", i), int'(in_ready), 1);
            drive(1'b1, 8'd225, 1'b0, 1'b0);
        end
        check("ft_in_ready", int'(in_ready), 0);
        check_out("ft", 1, 3600, 16, 0);
        drive(1'b1, 8'd225, 1'b1, 1'b0);
        check_out("ft_stall", 1, 3600, 16, 0);
        drive(1'b1, 8'd225, 1'b1, 1'b1);
        check("ft_hs_ready", int'(in_ready), 1);
        check("ft_hs_valid", int'(out_valid), 0);
        drive(1'b1, 8'd225, 1'b1, 1'b0);
        check_out("ft_next", 1, 225, 1, 0);
        drive(1'b0, 8'd0, 1'b0, 1'b1);
        check("ft_done_valid", int'(out_valid), 0);

        // Reset mid-vector discards the partial sum
        drive(1'b1, 8'd50, 1'b0, 1'b0);
        drive(1'b1, 8'd60, 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b0, 8'd0, 1'b0, 1'b0);
        rst = 1'b0;
        check("rmv_ready", int'(in_ready), 1);
        check_out("rmv_rst", 0, 0, 0, 0);
        drive(1'b1, 8'd7, 1'b1, 1'b0);
        check_out("rmv", 1, 7, 1, 0);
        drive(1'b0, 8'd0, 1'b0, 1'b1);
        check("rmv_done_valid", int'(out_valid), 0);

        // Reset while a result is held: it is never handshaked
        drive(1'b1, 8'd5, 1'b1, 1'b0);
        check_out("rh_hold", 1, 5, 1, 0);
        rst = 1'b1;
        drive(1'b0, 8'd0, 1'b0, 1'b0);
        rst = 1'b0;
        check("rh_ready", int'(in_ready), 1);
        check_out("rh_rst", 0, 0, 0, 0);
        drive(1'b0, 8'd0, 1'b0, 1'b1);
        check("rh_idle_valid", int'(out_valid), 0);

        // Wrap on a 10-bit accumulator: 5 * 225 = 1125 -> 101 with overflow
        for (int i = 0; i < 5; i++) drive_n(1'b1, 8'd225, (i == 4), 1'b0);
        check("ovf_valid", int'(n_out_valid), 1);
        check("ovf_sum", int'(n_out_sum), 101);
        check("ovf_count", int'(n_out_count), 5);
        check("ovf_flag", int'(n_out_overflow), 1);
        drive_n(1'b0, 8'd0, 1'b0, 1'b1);
        drive_n(1'b1, 8'd3, 1'b1, 1'b0);
        check("ovf_next_valid", int'(n_out_valid), 1);
        check("ovf_next_sum", int'(n_out_sum), 3);
        check("ovf_next_flag", int'(n_out_overflow), 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
